// File: rtl/pipe_skid_reg_if.sv
// rtl/pipe_skid_reg_if.sv - handshake/payload bundle for the skid register stage
interface pipe_skid_reg_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  PSR_Flush;
    logic                  PSR_In_Valid;
    logic [DATA_WIDTH-1:0] PSR_In_Data;
    logic                  PSR_In_Ready;
    logic                  PSR_Out_Valid;
    logic [DATA_WIDTH-1:0] PSR_Out_Data;
    logic                  PSR_Out_Ready;
    logic [1:0]            PSR_Count;

    // Driver side: feeds payloads, kills the pipe, accepts output.
    modport master (
        output PSR_Flush,
        output PSR_In_Valid,
        output PSR_In_Data,
        input  PSR_In_Ready,
        input  PSR_Out_Valid,
        input  PSR_Out_Data,
        output PSR_Out_Ready,
        input  PSR_Count
    );

    // Stage side: the skid register itself.
    modport slave (
        input  PSR_Flush,
        input  PSR_In_Valid,
        input  PSR_In_Data,
        output PSR_In_Ready,
        output PSR_Out_Valid,
        output PSR_Out_Data,
        input  PSR_Out_Ready,
        output PSR_Count
    );
endinterface

// File: rtl/pipe_skid_reg.sv
// rtl/pipe_skid_reg.sv - two-entry skid register pipeline stage with flush
module pipe_skid_reg #(
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                 PSR_Clk,
    input  logic                 PSR_Reset,
    pipe_skid_reg_if.slave       psr
);
    // EMPTY: nothing held; BUSY: main holds the output; FULL: main + skid.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] main_q, main_d;
    logic [DATA_WIDTH-1:0] skid_q, skid_d;
    logic                  in_fire;
    logic                  out_fire;

    // Ready and valid come only from registered state, so downstream ready
    // never reaches upstream ready combinationally.
    assign psr.PSR_In_Ready  = (state_q != FULL);
    assign psr.PSR_Out_Valid = (state_q != EMPTY);
    assign psr.PSR_Out_Data  = main_q;
    assign psr.PSR_Count     = (state_q == FULL) ? 2'd2 :
                               (state_q == BUSY) ? 2'd1 : 2'd0;

    assign in_fire  = psr.PSR_In_Valid  && (state_q != FULL);
    assign out_fire = psr.PSR_Out_Ready && (state_q != EMPTY);

    // Next state and storage updates; flush drops entries but leaves data alone.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (psr.PSR_Flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_d  = psr.PSR_In_Data;
                        state_d = BUSY;
                    end
                end
                BUSY: begin
                    if (in_fire && out_fire) begin
                        main_d = psr.PSR_In_Data;
                    end else if (in_fire) begin
                        skid_d  = psr.PSR_In_Data;
                        state_d = FULL;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        main_d  = skid_q;
                        state_d = BUSY;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // State and payload registers; reset wins over flush and handshakes.
    always_ff @(posedge PSR_Clk) begin
        if (PSR_Reset) begin
            state_q <= EMPTY;
            main_q  <= RESET_VALUE;
            skid_q  <= RESET_VALUE;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end
endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb/tb_pipe_skid_reg.sv - self-checking bench for pipe_skid_reg
module tb_pipe_skid_reg;
    localparam int          W     = 32;
    localparam logic [31:0] RST_V = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;

    logic [31:0] mq[$];
    logic [31:0] shown;
    int          delivered;

    pipe_skid_reg_if #(.DATA_WIDTH(W)) psr ();

    pipe_skid_reg #(.DATA_WIDTH(W), .RESET_VALUE(RST_V)) dut (
        .PSR_Clk   (clk),
        .PSR_Reset (rst),
        .psr       (psr.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".count"},     32'(psr.PSR_Count),     32'(mq.size()));
        check({tag, ".out_valid"}, 32'(psr.PSR_Out_Valid), 32'(mq.size() != 0));
        check({tag, ".in_ready"},  32'(psr.PSR_In_Ready),  32'(mq.size() < 2));
        check({tag, ".out_data"},  psr.PSR_Out_Data,       shown);
    endtask

    // Queue model: at most two held payloads, front is what the output shows.
    task automatic cycle(input string tag);
        logic in_fire, out_fire;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            shown = RST_V;
        end else begin
            in_fire  = psr.PSR_In_Valid && (mq.size() < 2);
            out_fire = psr.PSR_Out_Ready && (mq.size() > 0);
            if (out_fire) delivered++;
            if (psr.PSR_Flush) begin
                mq.delete();
            end else begin
                if (out_fire) void'(mq.pop_front());
                if (in_fire)  mq.push_back(psr.PSR_In_Data);
            end
            if (mq.size() > 0) shown = mq[0];
        end
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic r, input logic f);
        psr.PSR_In_Valid  = v;
        psr.PSR_In_Data   = d;
        psr.PSR_Out_Ready = r;
        psr.PSR_Flush     = f;
    endtask

    initial begin
        logic        pv, pr, pf, prst;
        logic [31:0] pd;
        shown     = 32'hDEAD_BEEF;
        delivered = 0;
        rst = 1'b1;
        drive(1'b1, 32'h5555_5555, 1'b0, 1'b1);
        cycle("reset");
        check("reset.data_const", psr.PSR_Out_Data, 32'h0000_0000);
        rst = 1'b0;

        drive(1'b0, 32'h0, 1'b1, 1'b0);
        cycle("idle");

        // Streaming at full rate.
        drive(1'b1, 32'h11, 1'b1, 1'b0); cycle("stream1");
        check("stream1.const", psr.PSR_Out_Data, 32'h11);
        drive(1'b1, 32'h22, 1'b1, 1'b0); cycle("stream2");
        check("stream2.const", psr.PSR_Out_Data, 32'h22);
        drive(1'b1, 32'h33, 1'b1, 1'b0); cycle("stream3");
        check("stream3.const", psr.PSR_Out_Data, 32'h33);
        check("stream3.count", 32'(psr.PSR_Count), 32'd1);
        drive(1'b0, 32'h0, 1'b1, 1'b0);  cycle("stream_drain");

        // Backpressure fills both entries, then drains in order.
        drive(1'b1, 32'hA0, 1'b0, 1'b0); cycle("bp1");
        drive(1'b1, 32'hB0, 1'b0, 1'b0); cycle("bp2");
        check("bp2.count", 32'(psr.PSR_Count), 32'd2);
        check("bp2.ready", 32'(psr.PSR_In_Ready), 32'd0);
        drive(1'b1, 32'hEE, 1'b0, 1'b0); cycle("bp_hold");
        check("bp_hold.const", psr.PSR_Out_Data, 32'hA0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);  cycle("bp_drain1");
        check("bp_drain1.const", psr.PSR_Out_Data, 32'hB0);
        check("bp_drain1.ready", 32'(psr.PSR_In_Ready), 32'd1);
        cycle("bp_drain2");

        // Flush while FULL with a payload offered.
        drive(1'b1, 32'hD0, 1'b0, 1'b0); cycle("fl_fill1");
        drive(1'b1, 32'hD1, 1'b0, 1'b0); cycle("fl_fill2");
        drive(1'b1, 32'hC0, 1'b1, 1'b1); cycle("flush");
        check("flush.count", 32'(psr.PSR_Count), 32'd0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);  cycle("flush_after1");
        cycle("flush_after2");

        // Reset while FULL, then a fresh payload is the first output.
        drive(1'b1, 32'h1, 1'b0, 1'b0); cycle("rf_fill1");
        drive(1'b1, 32'h2, 1'b0, 1'b0); cycle("rf_fill2");
        rst = 1'b1;
        cycle("rst_full");
        check("rst_full.data_const", psr.PSR_Out_Data, RST_V);
        rst = 1'b0;
        drive(1'b1, 32'h3, 1'b0, 1'b0); cycle("after_rst");
        check("after_rst.const", psr.PSR_Out_Data, 32'h3);

        // A reset pulse that ends before the clock edge does nothing.
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        rst = 1'b1; #2; rst = 1'b0;
        cycle("glitch_rst");
        check("glitch_rst.count", 32'(psr.PSR_Count), 32'd1);

        // Random traffic against the queue model plus stall-stability check.
        prst = 1'b0; pf = 1'b0; pv = psr.PSR_Out_Valid; pr = 1'b0; pd = psr.PSR_Out_Data;
        for (int i = 0; i < 10000; i++) begin
            rst = ($urandom % 500) == 0;
            drive(($urandom % 4) != 0, $urandom, ($urandom % 3) != 0, ($urandom % 50) == 0);
            pv = psr.PSR_Out_Valid; pr = psr.PSR_Out_Ready; pd = psr.PSR_Out_Data;
            pf = psr.PSR_Flush;     prst = rst;
            cycle("rand");
            if (pv && !pr && !pf && !prst)
                check("rand.stall_stable", psr.PSR_Out_Data, pd);
        end
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        cycle("final_drain1");
        cycle("final_drain2");
        check("final.count", 32'(psr.PSR_Count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
